// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: CPU-writable framebuffer scanned out as 1-bit-per-channel VGA.
// Each framebuffer pixel is replicated SCALE times horizontally and vertically.
module vga_fb_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int PIX_DIV   = 1,
   parameter int SCALE     = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [12:0] sys_addr,
   input  logic [31:0] sys_write_data,
   input  logic [3:0]  sys_wren,
   output logic        vga_r,
   output logic        vga_g,
   output logic        vga_b,
   output logic        vga_hsync_n,
   output logic        vga_vsync_n,
   output logic        vga_pixck_dbg
);

   localparam int HT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int VT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int FB_W  = H_VISIBLE / SCALE;
   localparam int FB_H  = V_VISIBLE / SCALE;
   localparam int WPL   = FB_W / 8;
   localparam int DEPTH = WPL * FB_H;
   localparam int HW    = $clog2(HT);
   localparam int VW    = $clog2(VT);
   localparam int AW    = $clog2(DEPTH);
   localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int SHIFT = $clog2(SCALE);

   localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
   localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
   localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
   localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
   localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_SUB    = VW'(SCALE - 1);
   localparam logic [AW-1:0] WPL_A    = AW'(WPL);
   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [12:0]   DEPTH_A  = 13'(DEPTH);

   logic [DW-1:0] div_q;
   logic [HW-1:0] hCnt_q;
   logic [VW-1:0] vCnt_q;
   logic [AW-1:0] lineBase_q;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   rdWord_q;
   logic [2:0]    sel_q;
   logic          vis_q, hsAct_q, vsAct_q;
   logic          r_q, g_q, b_q, hsN_q, vsN_q, pixck_q;

   logic          pixCe, lineEnd, visible, hsAct, vsAct, lastSub, wrEn;
   logic [HW-1:0] xFb;
   logic [AW-1:0] rdAddr, wrIdx;
   logic [2:0]    pixRgb;

   assign pixCe = (div_q == '0);

   // Stage 0: decode the current beam position into a framebuffer address and sync windows.
   always_comb begin
      lineEnd = (hCnt_q == H_LAST);
      visible = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
      hsAct   = (hCnt_q >= HS_START) && (hCnt_q < HS_END);
      vsAct   = (vCnt_q >= VS_START) && (vCnt_q < VS_END);
      lastSub = ((vCnt_q & V_SUB) == V_SUB);
      xFb     = hCnt_q >> SHIFT;
      rdAddr  = visible ? (lineBase_q + AW'(xFb >> 3)) : '0;
      wrEn    = (sys_wren != 4'h0) && (sys_addr < DEPTH_A);
      wrIdx   = sys_addr[AW-1:0];
      pixRgb  = 3'(rdWord_q >> {sel_q, 2'b00});
   end

   // Non-blocking read and write of the same word give read-first behaviour.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wrEn && sys_wren[b]) begin
            mem[wrIdx][8*b +: 8] <= sys_write_data[8*b +: 8];
         end
      end
      if (pixCe) begin
         rdWord_q <= mem[rdAddr];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_q      <= '0;
         hCnt_q     <= '0;
         vCnt_q     <= '0;
         lineBase_q <= '0;
         sel_q      <= '0;
         vis_q      <= 1'b0;
         hsAct_q    <= 1'b0;
         vsAct_q    <= 1'b0;
         r_q        <= 1'b0;
         g_q        <= 1'b0;
         b_q        <= 1'b0;
         hsN_q      <= 1'b1;
         vsN_q      <= 1'b1;
         pixck_q    <= 1'b0;
      end else begin
         div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         if (pixCe) begin
            pixck_q <= ~pixck_q;
            if (lineEnd) begin
               hCnt_q <= '0;
               if (vCnt_q == V_LAST) begin
                  vCnt_q     <= '0;
                  lineBase_q <= '0;
               end else begin
                  vCnt_q <= vCnt_q + 1'b1;
                  // Step to the next framebuffer row after the last replicated line of this one.
                  if (lastSub && (vCnt_q < V_VIS)) begin
                     lineBase_q <= lineBase_q + WPL_A;
                  end
               end
            end else begin
               hCnt_q <= hCnt_q + 1'b1;
            end
            sel_q   <= xFb[2:0];
            vis_q   <= visible;
            hsAct_q <= hsAct;
            vsAct_q <= vsAct;
            r_q     <= vis_q & pixRgb[2];
            g_q     <= vis_q & pixRgb[1];
            b_q     <= vis_q & pixRgb[0];
            hsN_q   <= ~hsAct_q;
            vsN_q   <= ~vsAct_q;
         end
      end
   end

   assign vga_r         = r_q;
   assign vga_g         = g_q;
   assign vga_b         = b_q;
   assign vga_hsync_n   = hsN_q;
   assign vga_vsync_n   = vsN_q;
   assign vga_pixck_dbg = pixck_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: two scaled-down scanout instances (different divider and scale) checked
// every clock against a reference that derives each pixel from its raster position.
module tb_vga_fb_scanout;

   localparam int HV  = 64;
   localparam int HFP = 4;
   localparam int HSY = 8;
   localparam int HBP = 4;
   localparam int VV  = 32;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int HT  = HV + HFP + HSY + HBP;
   localparam int VT  = VV + VFP + VSY + VBP;
   localparam logic [4:0] IDLE = 5'b000_11;

   logic        clk = 1'b0;
   logic        resetn;
   logic [12:0] sys_addr;
   logic [31:0] sys_write_data;
   logic [3:0]  sys_wren;
   logic        rA, gA, bA, hsA, vsA, pcA;
   logic        rB, gB, bB, hsB, vsB, pcB;

   logic [31:0] fbModel [2][64];
   int          nEdge [2];
   int          nCe [2];
   logic [4:0]  s1 [2];
   logic [4:0]  s2 [2];
   logic        pix [2];
   int          total = 0;
   int          bad   = 0;
   int          cycle = 0;

   always #5 clk = ~clk;

   vga_fb_scanout #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .PIX_DIV(1), .SCALE(4)
   ) dutA (
      .clk(clk), .resetn(resetn), .sys_addr(sys_addr), .sys_write_data(sys_write_data),
      .sys_wren(sys_wren), .vga_r(rA), .vga_g(gA), .vga_b(bA),
      .vga_hsync_n(hsA), .vga_vsync_n(vsA), .vga_pixck_dbg(pcA)
   );

   vga_fb_scanout #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .PIX_DIV(3), .SCALE(2)
   ) dutB (
      .clk(clk), .resetn(resetn), .sys_addr(sys_addr), .sys_write_data(sys_write_data),
      .sys_wren(sys_wren), .vga_r(rB), .vga_g(gB), .vga_b(bB),
      .vga_hsync_n(hsB), .vga_vsync_n(vsB), .vga_pixck_dbg(pcB)
   );

   function automatic int scaleOf(input int d);
      return (d == 0) ? 4 : 2;
   endfunction

   function automatic int divOf(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int wplOf(input int d);
      return (HV / scaleOf(d)) / 8;
   endfunction

   function automatic int depthOf(input int d);
      return wplOf(d) * (VV / scaleOf(d));
   endfunction

   // Expected {r,g,b,hsync_n,vsync_n} for the p-th pixel slot since reset release.
   function automatic logic [4:0] refPixel(input int d, input int p);
      int          h, v, x, y, s;
      logic [31:0] w;
      logic [2:0]  rgb;
      logic        hs, vs;
      h   = p % HT;
      v   = (p / HT) % VT;
      rgb = 3'b000;
      if (h < HV && v < VV) begin
         s   = scaleOf(d);
         x   = h / s;
         y   = v / s;
         w   = fbModel[d][y * wplOf(d) + x / 8];
         rgb = {w[4*(x%8)+2], w[4*(x%8)+1], w[4*(x%8)]};
      end
      hs = (h >= HV + HFP) && (h < HV + HFP + HSY);
      vs = (v >= VV + VFP) && (v < VV + VFP + VSY);
      return {rgb, ~hs, ~vs};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
      end
   endtask

   // Expected output is the reference pixel from two pixel enables earlier; memory reads see pre-write data.
   task automatic advanceModel();
      int ai;
      ai = int'(sys_addr);
      for (int d = 0; d < 2; d++) begin
         if (!resetn) begin
            nEdge[d] = 0;
            nCe[d]   = 0;
            s1[d]    = IDLE;
            s2[d]    = IDLE;
            pix[d]   = 1'b0;
         end else begin
            nEdge[d]++;
            if ((nEdge[d] - 1) % divOf(d) == 0) begin
               s2[d]  = s1[d];
               s1[d]  = refPixel(d, nCe[d]);
               nCe[d]++;
               pix[d] = ~pix[d];
            end
         end
         if (sys_wren != 4'h0 && ai < depthOf(d)) begin
            for (int b = 0; b < 4; b++) begin
               if (sys_wren[b]) fbModel[d][ai][8*b +: 8] = sys_write_data[8*b +: 8];
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic rn, input logic [12:0] a, input logic [31:0] dat, input logic [3:0] w);
      resetn         = rn;
      sys_addr       = a;
      sys_write_data = dat;
      sys_wren       = w;
      @(posedge clk);
      advanceModel();
      @(negedge clk);
      cycle++;
      checkOutput("A.rgb",     32'({rA, gA, bA}), 32'(s2[0][4:2]));
      checkOutput("A.hsync_n", 32'(hsA),          32'(s2[0][1]));
      checkOutput("A.vsync_n", 32'(vsA),          32'(s2[0][0]));
      checkOutput("A.pixck",   32'(pcA),          32'(pix[0]));
      checkOutput("B.rgb",     32'({rB, gB, bB}), 32'(s2[1][4:2]));
      checkOutput("B.hsync_n", 32'(hsB),          32'(s2[1][1]));
      checkOutput("B.vsync_n", 32'(vsB),          32'(s2[1][0]));
      checkOutput("B.pixck",   32'(pcB),          32'(pix[1]));
   endtask

   task automatic idleCycle();
      applyStimulus(1'b1, 13'($urandom_range(0, 8191)), $urandom, 4'h0);
   endtask

   task automatic randomCycle();
      logic [12:0] ra;
      case ($urandom_range(0, 7))
         0:       ra = 13'd8191;
         1:       ra = 13'd2400;
         2:       ra = 13'd16;
         3:       ra = 13'd64;
         default: ra = 13'($urandom_range(0, 70));
      endcase
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, ra, $urandom, 4'($urandom_range(0, 15)));
      else                           applyStimulus(1'b1, ra, $urandom, 4'h0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 13'd0, 32'h0, 4'h0);
      // Framebuffer is not cleared by reset, so give it known contents while still held in reset.
      for (int a = 0; a < 64; a++) applyStimulus(1'b0, 13'(a), (a == 0) ? 32'h0000_0007 : 32'h0, 4'hF);
      applyStimulus(1'b1, 13'd3,    32'h7777_7777, 4'b0010);
      applyStimulus(1'b1, 13'd2400, 32'hFFFF_FFFF, 4'hF);
      applyStimulus(1'b1, 13'd8191, 32'hFFFF_FFFF, 4'hF);
      applyStimulus(1'b1, 13'd16,   32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 2 * HT * VT; i++) idleCycle();
      for (int i = 0; i < 12000; i++) begin
         if (i == 6000) begin
            applyStimulus(1'b0, 13'd0, 32'h0, 4'h0);
            applyStimulus(1'b0, 13'd0, 32'h0, 4'h0);
         end
         randomCycle();
      end
      for (int i = 0; i < 3000; i++) idleCycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
